axil_reg_bank: RTL and testbench

AXI4-Lite slave register bank that sits directly downstream of the RBCP-to-AXI bridge and terminates its single-beat, single-byte-strobe transactions. It provides N_CTRL read/write control registers, driven out to fabric logic, and N_STAT read-only status registers, sampled from fabric logic. Independent write and read state machines give every transaction exactly one response, and the response is held until the master accepts it.

---
 rtl/axil_pkg.sv | 20 ++
 rtl/axil_reg_decode.sv | 37 +++
 rtl/axil_reg_bank.sv | 214 +++++++++++++++++++++
 tb/tb_axil_reg_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared constants and FSM encodings for the AXI4-Lite register bank
package axil_pkg;

    localparam int REG_IDX_W = 6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/axil_reg_decode.sv
// rtl/axil_reg_decode.sv - combinational address decode into control/status/out-of-window
module axil_reg_decode
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          N_CTRL    = 8,
    parameter int          N_STAT    = 8
) (
    input  logic [31:0]          addr,
    output logic                 hit_ctrl,
    output logic                 hit_stat,
    output logic [REG_IDX_W-1:0] idx,
    output logic [1:0]           resp
);

    // Byte offset bits select nothing; a word index beyond the populated registers is a decode error.
    logic [1:0] unused_byte_bits;
    assign unused_byte_bits = addr[1:0];

    // Window compare on the upper address bits, then split the word index into control/status ranges.
    always_comb begin
        idx      = addr[7:2];
        hit_ctrl = 1'b0;
        hit_stat = 1'b0;
        resp     = RESP_DECERR;
        if (addr[31:8] == BASE_ADDR[31:8]) begin
            if (int'(addr[7:2]) < N_CTRL) begin
                hit_ctrl = 1'b1;
                resp     = RESP_OKAY;
            end else if (int'(addr[7:2]) < N_CTRL + N_STAT) begin
                hit_stat = 1'b1;
                resp     = RESP_OKAY;
            end
        end
    end

endmodule

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - AXI4-Lite slave with RW control and RO status registers
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          N_CTRL    = 8,
    parameter int          N_STAT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [32*N_CTRL-1:0]  ctrl_o,
    input  logic [32*N_STAT-1:0]  stat_i,
    output logic [N_CTRL-1:0]     wr_pulse
);

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ctrl_q [N_CTRL];
    logic [31:0] ctrl_d [N_CTRL];
    logic [N_CTRL-1:0] wr_pulse_q, wr_pulse_d;
    logic [31:0] stat_w [N_STAT];

    logic unused_prot;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    // Readies depend only on registered state, never on the incoming valids.
    assign s_axi_awready = ~aw_held_q & ~bvalid_q;
    assign s_axi_wready  = ~w_held_q & ~bvalid_q;
    assign s_axi_arready = ~rvalid_q;

    logic aw_fire, w_fire, ar_fire, have_aw, have_w;
    assign aw_fire = s_axi_awvalid & s_axi_awready;
    assign w_fire  = s_axi_wvalid & s_axi_wready;
    assign ar_fire = s_axi_arvalid & s_axi_arready;
    assign have_aw = aw_held_q | aw_fire;
    assign have_w  = w_held_q | w_fire;

    // The write uses whichever half arrived earlier from the hold registers and the later half live.
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    assign wr_addr = aw_held_q ? awaddr_q : s_axi_awaddr;
    assign wr_data = w_held_q ? wdata_q : s_axi_wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_axi_wstrb;

    logic                 aw_hit_ctrl, aw_hit_stat, ar_hit_ctrl, ar_hit_stat;
    logic [REG_IDX_W-1:0] aw_idx, ar_idx;
    logic [1:0]           aw_resp, ar_resp;

    axil_reg_decode #(.BASE_ADDR(BASE_ADDR), .N_CTRL(N_CTRL), .N_STAT(N_STAT)) u_aw_decode (
        .addr(wr_addr), .hit_ctrl(aw_hit_ctrl), .hit_stat(aw_hit_stat), .idx(aw_idx), .resp(aw_resp)
    );

    axil_reg_decode #(.BASE_ADDR(BASE_ADDR), .N_CTRL(N_CTRL), .N_STAT(N_STAT)) u_ar_decode (
        .addr(s_axi_araddr), .hit_ctrl(ar_hit_ctrl), .hit_stat(ar_hit_stat), .idx(ar_idx), .resp(ar_resp)
    );

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl_out
        assign ctrl_o[32*k +: 32] = ctrl_q[k];
    end

    for (genvar j = 0; j < N_STAT; j++) begin : g_stat_in
        assign stat_w[j] = stat_i[32*j +: 32];
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;
    assign wr_pulse     = wr_pulse_q;

    // Write FSM: collect AW and W, execute once both are present, hold B until accepted.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        for (int k = 0; k < N_CTRL; k++) ctrl_d[k] = ctrl_q[k];
        case (wr_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                if (have_aw && have_w) begin
                    bvalid_d   = 1'b1;
                    bresp_d    = aw_hit_stat ? RESP_SLVERR : aw_resp;
                    wr_state_d = W_RESP;
                    if (aw_hit_ctrl) begin
                        for (int k = 0; k < N_CTRL; k++) begin
                            if (aw_idx == REG_IDX_W'(k)) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (wr_strb[b]) ctrl_d[k][8*b +: 8] = wr_data[8*b +: 8];
                                end
                                wr_pulse_d[k] = |wr_strb;
                            end
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d   = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read FSM: register the selected value on the AR handshake, hold R until accepted.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rvalid_d   = 1'b1;
                    rresp_d    = ar_resp;
                    rdata_d    = '0;
                    rd_state_d = R_RESP;
                    for (int k = 0; k < N_CTRL; k++) begin
                        if (ar_hit_ctrl && ar_idx == REG_IDX_W'(k)) rdata_d = ctrl_q[k];
                    end
                    for (int j = 0; j < N_STAT; j++) begin
                        if (ar_hit_stat && ar_idx == REG_IDX_W'(N_CTRL + j)) rdata_d = stat_w[j];
                    end
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State registers; reset drops any pending transaction and unaccepted response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            for (int k = 0; k < N_CTRL; k++) ctrl_q[k] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            for (int k = 0; k < N_CTRL; k++) ctrl_q[k] <= ctrl_d[k];
        end
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// tb/tb_axil_reg_bank.sv - scoreboard bench for the AXI4-Lite register bank
module tb_axil_reg_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_axi_awaddr;
    logic [2:0]   s_axi_awprot;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [31:0]  s_axi_araddr;
    logic [2:0]   s_axi_arprot;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic [255:0] ctrl_o;
    logic [255:0] stat_i;
    logic [7:0]   wr_pulse;

    int errors = 0;
    int checks = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    axil_reg_bank #(.BASE_ADDR(32'h0000_0000), .N_CTRL(8), .N_STAT(8)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ctrl_o(ctrl_o), .stat_i(stat_i), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation whenever a response is accepted.
    always @(negedge clk) begin
        if (!rst && s_axi_bvalid && s_axi_bready) begin
            check("b_expected_present", 64'(exp_b.size() != 0), 64'(1));
            if (exp_b.size() != 0) check("bresp", 64'(s_axi_bresp), 64'(exp_b.pop_front()));
        end
        if (!rst && s_axi_rvalid && s_axi_rready) begin
            check("r_expected_present", 64'(exp_r.size() != 0), 64'(1));
            if (exp_r.size() != 0) check("rresp_rdata", 64'({s_axi_rresp, s_axi_rdata}), 64'(exp_r.pop_front()));
        end
    end

    task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] resp);
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        exp_b.push_back(resp);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] addr, input logic [1:0] resp, input logic [31:0] data);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        exp_r.push_back({resp, data});
        tick();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic finish_b(input int delay);
        int n = 0;
        while (!s_axi_bvalid && n < 20) begin tick(); n++; end
        check("bvalid_seen", 64'(s_axi_bvalid), 64'(1));
        repeat (delay) tick();
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic finish_r(input int delay);
        int n = 0;
        while (!s_axi_rvalid && n < 20) begin tick(); n++; end
        check("rvalid_seen", 64'(s_axi_rvalid), 64'(1));
        repeat (delay) tick();
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_vec;
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        stat_i = '0;
        stat_i[31:0]  = 32'hDEAD_BEEF;
        stat_i[63:32] = 32'h0101_0101;
        repeat (3) tick();

        check("rst_awready", 64'(s_axi_awready), 64'(1));
        check("rst_wready", 64'(s_axi_wready), 64'(1));
        check("rst_arready", 64'(s_axi_arready), 64'(1));
        check("rst_bvalid", 64'(s_axi_bvalid), 64'(0));
        check("rst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check("rst_resp", 64'({s_axi_bresp, s_axi_rresp}), 64'(0));
        check("rst_rdata", 64'(s_axi_rdata), 64'(0));
        check("rst_ctrl_zero", 64'(ctrl_o == '0), 64'(1));
        check("rst_wr_pulse", 64'(wr_pulse), 64'(0));
        rst = 1'b0;
        tick();

        // Byte-lane write, AW and W in the same cycle.
        issue_write(32'h04, 32'hA5A5_A5A5, 4'b0100, 2'b00);
        check("bl_bvalid_latency", 64'(s_axi_bvalid), 64'(1));
        check("bl_ctrl1", 64'(ctrl_o[63:32]), 64'(32'h00A5_0000));
        check("bl_wr_pulse", 64'(wr_pulse), 64'(8'b0000_0010));
        check("bl_awready_low", 64'(s_axi_awready), 64'(0));
        tick();
        check("bl_bvalid_hold", 64'(s_axi_bvalid), 64'(1));
        check("bl_wr_pulse_one_cycle", 64'(wr_pulse), 64'(0));
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("bl_bvalid_drop", 64'(s_axi_bvalid), 64'(0));
        check("bl_readies_back", 64'({s_axi_awready, s_axi_wready}), 64'(2'b11));

        // Preload reg 0, then split write: W at cycle 0, AW at cycle 3.
        issue_write(32'h00, 32'h1122_3344, 4'b1111, 2'b00);
        check("pre_wr_pulse", 64'(wr_pulse), 64'(8'h01));
        finish_b(1);
        s_axi_wdata = 32'hFFFF_FF3C;
        s_axi_wstrb = 4'b0001;
        s_axi_wvalid = 1'b1;
        exp_b.push_back(2'b00);
        tick();
        s_axi_wvalid = 1'b0;
        check("split_wready_low_c1", 64'(s_axi_wready), 64'(0));
        check("split_awready_c1", 64'(s_axi_awready), 64'(1));
        tick();
        check("split_wready_low_c2", 64'(s_axi_wready), 64'(0));
        tick();
        check("split_no_bvalid_c3", 64'(s_axi_bvalid), 64'(0));
        s_axi_awaddr = 32'h00;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("split_bvalid_c4", 64'(s_axi_bvalid), 64'(1));
        check("split_ctrl0", 64'(ctrl_o[31:0]), 64'(32'h1122_333C));
        finish_b(1);

        // Status read with rready delayed five cycles; input changes do not disturb held data.
        issue_read(32'h20, 2'b00, 32'hDEAD_BEEF);
        stat_i[31:0] = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            check("stat_rvalid_hold", 64'(s_axi_rvalid), 64'(1));
            check("stat_rdata_hold", 64'(s_axi_rdata), 64'(32'hDEAD_BEEF));
            check("stat_arready_low", 64'(s_axi_arready), 64'(0));
            tick();
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("stat_arready_back", 64'(s_axi_arready), 64'(1));

        // Error responses and a no-strobe write.
        exp_vec = {192'h0, 32'h00A5_0000, 32'h1122_333C};
        issue_write(32'h20, 32'hFFFF_FFFF, 4'b1111, 2'b10);
        check("slverr_no_pulse", 64'(wr_pulse), 64'(0));
        check("slverr_ctrl_unchanged", 64'(ctrl_o == exp_vec), 64'(1));
        finish_b(1);
        issue_read(32'h20, 2'b00, 32'h0BAD_F00D);
        finish_r(1);
        issue_write(32'h100, 32'hFFFF_FFFF, 4'b1111, 2'b11);
        check("decerr_w_ctrl_unchanged", 64'(ctrl_o == exp_vec), 64'(1));
        finish_b(1);
        issue_read(32'h100, 2'b11, 32'h0);
        finish_r(1);
        issue_read(32'h50, 2'b11, 32'h0);
        finish_r(1);
        issue_write(32'h0C, 32'hFFFF_FFFF, 4'b0000, 2'b00);
        check("nostrb_no_pulse", 64'(wr_pulse), 64'(0));
        check("nostrb_ctrl3", 64'(ctrl_o[127:96]), 64'(0));
        finish_b(1);
        issue_read(32'h06, 2'b00, 32'h00A5_0000);
        finish_r(1);

        // Collision: read of reg 2 on the same edge the write to reg 2 executes.
        s_axi_awaddr = 32'h08; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'b1111; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h08; s_axi_arvalid = 1'b1;
        exp_b.push_back(2'b00);
        exp_r.push_back({2'b00, 32'h0});
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("coll_ctrl2", 64'(ctrl_o[95:64]), 64'(32'h1234_5678));
        tick();
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        issue_read(32'h08, 2'b00, 32'h1234_5678);
        finish_r(1);

        // Reset while a write response is pending.
        s_axi_awaddr = 32'h14; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'b1111; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("rstmid_bvalid_before", 64'(s_axi_bvalid), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_bvalid", 64'(s_axi_bvalid), 64'(0));
        check("rstmid_ctrl_zero", 64'(ctrl_o == '0), 64'(1));
        check("rstmid_readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));
        issue_write(32'h14, 32'h0F0F_0F0F, 4'b1111, 2'b00);
        check("post_rst_ctrl5", 64'(ctrl_o[191:160]), 64'(32'h0F0F_0F0F));
        check("post_rst_pulse", 64'(wr_pulse), 64'(8'b0010_0000));
        finish_b(1);
        issue_read(32'h14, 2'b00, 32'h0F0F_0F0F);
        finish_r(1);

        repeat (3) tick();
        check("b_queue_drained", 64'(exp_b.size()), 64'(0));
        check("r_queue_drained", 64'(exp_r.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
